// File: rtl/calc_bcd_core.sv
// Two-operand decimal calculator core: digit entry, add (or |A-B| with CALC_SUB_EN defined),
// and sequential double-dabble conversion of the result to packed BCD.
module calc_bcd_core #(
    parameter int unsigned DIGITS = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [3:0]                  i_digit_in,
    input  logic                        i_digit_valid,
    input  logic                        i_next_op,
    input  logic                        i_compute,
    input  logic                        i_op_sel,
    input  logic                        i_clear,
    output logic [4*DIGITS-1:0]         o_entry_bcd,
    output logic                        o_entering_b,
    output logic                        o_busy,
    output logic                        o_result_valid,
    output logic [4*(DIGITS+1)-1:0]     o_result_bcd,
    output logic                        o_result_neg
);

    localparam int unsigned W  = $clog2(10 ** DIGITS);
    localparam int unsigned RW = W + 1;
    localparam int unsigned DW = 4 * DIGITS;
    localparam int unsigned RD = 4 * (DIGITS + 1);
    localparam int unsigned CW = $clog2(RW);

    typedef enum logic [2:0] {
        StEnterA,
        StEnterB,
        StCalc,
        StConvert,
        StDone
    } state_e;

    state_e          r_state;
    logic [W-1:0]    r_a_bin, r_b_bin;
    logic [DW-1:0]   r_a_bcd, r_b_bcd;
    logic [3:0]      r_cnt;
    logic [RW-1:0]   r_bin;
    logic [RD-1:0]   r_acc;
    logic [CW-1:0]   r_shift_cnt;
    logic            r_neg_calc;
    logic [RD-1:0]   r_result_bcd;
    logic            r_result_neg;
    logic            r_busy;
    logic            r_valid;
    logic            r_entering_b;

    logic            w_digit_ok;
    logic            w_can_append;
    logic [W-1:0]    w_cur_bin, w_app_bin;
    logic [DW-1:0]   w_cur_bcd, w_app_bcd;
    logic [RW-1:0]   w_calc_bin;
    logic            w_calc_neg;
    logic [RD-1:0]   w_acc_adj, w_acc_next;
    logic [RW-1:0]   w_bin_next;

    assign w_digit_ok   = (i_digit_in <= 4'd9);
    assign w_can_append = w_digit_ok && (r_cnt < 4'(DIGITS));
    assign w_cur_bin    = (r_state == StEnterB) ? r_b_bin : r_a_bin;
    assign w_cur_bcd    = (r_state == StEnterB) ? r_b_bcd : r_a_bcd;
    assign w_app_bin    = w_cur_bin * W'(10) + W'(i_digit_in);
    assign w_app_bcd    = (w_cur_bcd << 4) | DW'(i_digit_in);

`ifdef CALC_SUB_EN
    logic r_op_sub;

    always_comb begin
        w_calc_bin = RW'(r_a_bin) + RW'(r_b_bin);
        w_calc_neg = 1'b0;
        if (r_op_sub) begin
            if (r_a_bin >= r_b_bin) begin
                w_calc_bin = RW'(r_a_bin) - RW'(r_b_bin);
            end else begin
                w_calc_bin = RW'(r_b_bin) - RW'(r_a_bin);
                w_calc_neg = 1'b1;
            end
        end
    end
`else
    logic w_unused_op_sel;

    assign w_unused_op_sel = i_op_sel;
    assign w_calc_bin      = RW'(r_a_bin) + RW'(r_b_bin);
    assign w_calc_neg      = 1'b0;
`endif

    // Double-dabble step: correct nibbles >= 5, then shift {acc, bin} left by one.
    always_comb begin
        w_acc_adj = r_acc;
        for (int i = 0; i < int'(RD / 4); i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
        w_acc_next = {w_acc_adj[RD-2:0], r_bin[RW-1]};
        w_bin_next = {r_bin[RW-2:0], 1'b0};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StEnterA;
            r_a_bin      <= '0;
            r_b_bin      <= '0;
            r_a_bcd      <= '0;
            r_b_bcd      <= '0;
            r_cnt        <= '0;
            r_bin        <= '0;
            r_acc        <= '0;
            r_shift_cnt  <= '0;
            r_neg_calc   <= 1'b0;
            r_result_bcd <= '0;
            r_result_neg <= 1'b0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_entering_b <= 1'b0;
`ifdef CALC_SUB_EN
            r_op_sub     <= 1'b0;
`endif
        end else if (i_clear) begin
            r_state      <= StEnterA;
            r_a_bin      <= '0;
            r_b_bin      <= '0;
            r_a_bcd      <= '0;
            r_b_bcd      <= '0;
            r_cnt        <= '0;
            r_result_bcd <= '0;
            r_result_neg <= 1'b0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_entering_b <= 1'b0;
        end else begin
            unique case (r_state)
                StEnterA: begin
                    if (i_compute) begin
                        r_state <= StEnterA;
                    end else if (i_next_op) begin
                        r_state      <= StEnterB;
                        r_b_bin      <= '0;
                        r_b_bcd      <= '0;
                        r_cnt        <= '0;
                        r_entering_b <= 1'b1;
                    end else if (i_digit_valid && w_can_append) begin
                        r_a_bin <= w_app_bin;
                        r_a_bcd <= w_app_bcd;
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                StEnterB: begin
                    if (i_compute) begin
`ifdef CALC_SUB_EN
                        r_op_sub     <= i_op_sel;
`endif
                        r_state      <= StCalc;
                        r_busy       <= 1'b1;
                        r_entering_b <= 1'b0;
                    end else if (i_next_op) begin
                        r_state <= StEnterB;
                    end else if (i_digit_valid && w_can_append) begin
                        r_b_bin <= w_app_bin;
                        r_b_bcd <= w_app_bcd;
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                StCalc: begin
                    r_bin       <= w_calc_bin;
                    r_neg_calc  <= w_calc_neg;
                    r_acc       <= '0;
                    r_shift_cnt <= '0;
                    r_state     <= StConvert;
                end
                StConvert: begin
                    r_acc <= w_acc_next;
                    r_bin <= w_bin_next;
                    if (r_shift_cnt == CW'(RW - 1)) begin
                        r_result_bcd <= w_acc_next;
                        r_result_neg <= r_neg_calc;
                        r_valid      <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= StDone;
                    end else begin
                        r_shift_cnt <= r_shift_cnt + CW'(1);
                    end
                end
                StDone: begin
                    // A fresh digit starts a new A entry; the old result stays visible.
                    if (!i_compute && !i_next_op && i_digit_valid && w_digit_ok) begin
                        r_a_bin <= W'(i_digit_in);
                        r_a_bcd <= DW'(i_digit_in);
                        r_b_bin <= '0;
                        r_b_bcd <= '0;
                        r_cnt   <= 4'd1;
                        r_valid <= 1'b0;
                        r_state <= StEnterA;
                    end
                end
                default: r_state <= StEnterA;
            endcase
        end
    end

    assign o_entry_bcd    = (r_state == StEnterA) ? r_a_bcd : r_b_bcd;
    assign o_entering_b   = r_entering_b;
    assign o_busy         = r_busy;
    assign o_result_valid = r_valid;
    assign o_result_bcd   = r_result_bcd;
    assign o_result_neg   = r_result_neg;

endmodule

// File: doc/calc_bcd_core.md
Name: calc_bcd_core

Overview:
- Parametrised successor to the fixed 3-digit dipswitch/adder/divider chain.
- Collects two decimal operands digit by digit and computes A+B, or |A−B| with a sign flag.
- Converts the binary result to packed BCD with a sequential double-dabble engine and presents it with a valid/busy handshake.
- Sits between the debounced input-digit/button logic and the 7-segment driver.

Parameters:
- DIGITS, 3, number of decimal digits per operand (1..6).
- localparam W = bits needed for 10^DIGITS−1 (DIGITS=3 → 10).
- localparam RW = W+1, the result width (DIGITS=3 → 11).
- localparam DW = 4*DIGITS; RD = 4*(DIGITS+1).

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- digit_in  in  4  BCD digit from the switches
- digit_valid  in  1  one-cycle pulse: append digit_in to the current operand
- next_op  in  1  one-cycle pulse: finish operand A, start operand B
- compute  in  1  one-cycle pulse: start the calculation
- op_sel  in  1  0 = add, 1 = subtract
- clear  in  1  synchronous clear to the empty A entry
- entry_bcd  out  DW  packed BCD of the operand currently being entered
- entering_b  out  1  high while operand B is being entered
- busy  out  1  high in CALC and CONVERT
- result_valid  out  1  high in DONE
- result_bcd  out  RD  packed BCD magnitude of the result
- result_neg  out  1  result sign

Behaviour:
- Reset (rst=0, async): state ENTER_A; all outputs, operands and counters = 0.
- States: ENTER_A, ENTER_B, CALC, CONVERT, DONE.
- Priority per cycle: clear > compute > next_op > digit_valid. Lower-priority pulses in the same cycle are dropped.
- clear, any state: → ENTER_A; operands, digit count, result_bcd, result_neg all zeroed.
- Digit entry (ENTER_A/ENTER_B):
  - Accepted only if digit_in ≤ 9 and digit count < DIGITS.
  - On accept: binary = binary*10 + digit_in; BCD shifts left one nibble; count+1.
  - Digits > 9, or a digit arriving with count = DIGITS, are ignored with no state change.
- ENTER_A + next_op: → ENTER_B; B and the count cleared; entering_b = 1.
- ENTER_A + compute: ignored.
- ENTER_B + compute: op_sel is latched; → CALC.
- ENTER_B + next_op: ignored.
- CALC, one cycle:
  - Add: r = A+B, zero-extended to RW bits; neg = 0.
  - Subtract: if A ≥ B then r = A−B, neg = 0; else r = B−A, neg = 1.
  - → CONVERT; shift counter = 0; BCD accumulator = 0.
- CONVERT, one shift per cycle, for RW cycles:
  - Add 3 to each accumulator nibble ≥ 5, then shift {acc, r} left by 1.
  - After the RW-th shift: result_bcd ← acc, result_neg ← neg; → DONE.
- Latency: compute sampled at edge k → result_valid = 1 after edge k+2+RW−1 = k+RW+1 (DIGITS=3: 12 edges after k).
  - busy = 1 from edge k through the edge where DONE is entered.
- DONE:
  - result_valid = 1; result_bcd and result_neg are held.
  - An accepted digit_valid clears both operands, enters ENTER_A with that digit as A's first digit, and drops result_valid.
  - next_op and compute are ignored.
  - result_bcd keeps its last value until a new conversion completes or clear is applied.
- During CALC/CONVERT, digit_valid, next_op and compute are ignored; only clear or reset aborts.
- entry_bcd shows A in ENTER_A, B in ENTER_B, and holds B in CALC/CONVERT/DONE.
- Reset mid-conversion: immediate return to reset state; no partial result is visible.

Optional Feature:
- Macro CALC_SUB_EN.
- Defined: subtract path as described; op_sel honoured.
- Undefined: op_sel ignored; always add; result_neg tied to 0; no comparator or subtractor logic.

Test Plan:
- Digits 1,2,3, next_op, digits 4,5,6, op_sel=0, compute → busy for 12 cycles, then result_valid=1, result_bcd=16'h0579, neg=0.
- A=999, B=999, add → result_bcd=16'h1998, the maximum, with no truncation.
- CALC_SUB_EN defined: A=100, B=250, op_sel=1 → result_bcd=16'h0150, neg=1. A=250, B=250 → 16'h0000, neg=0.
- In ENTER_A: digits 1,2,3,4 then 0xB → entry_bcd=12'h123; the 4th digit and the invalid digit are ignored.
- Assert rst low 5 cycles after compute → all outputs 0 immediately, state ENTER_A. clear together with compute in ENTER_B → ENTER_A, busy never asserted.
- In DONE, digit 7 → result_valid drops next cycle, entry_bcd=12'h007, entering_b=0, result_bcd still holds the previous value.
